// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry fetch-to-decode FIFO with flush, hold-gated pop and valid/ready on both sides.
// Optional macro FETCH_QUEUE_BYPASS_EN forwards a push straight to the outputs when the queue is empty.
`default_nettype none

module fetch_queue #(
   parameter int                INST_W     = 32,
   parameter int                INT_W      = 8,
   parameter int                DEPTH      = 4,
   parameter logic [INST_W-1:0] NOP_INST   = 32'h00000013,
   parameter logic [2:0]        HOLD_LEVEL = 3'b010
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push_valid_i,
   output logic                       push_ready_o,
   input  logic [INST_W-1:0]          inst_i,
   input  logic [INST_W-1:0]          inst_addr_i,
   input  logic [INT_W-1:0]           interrupt_flag_i,
   input  logic                       pop_ready_i,
   input  logic [2:0]                 hold_flag_i,
   input  logic                       flush_i,
   output logic                       pop_valid_o,
   output logic [INST_W-1:0]          inst_o,
   output logic [INST_W-1:0]          inst_addr_o,
   output logic [INT_W-1:0]           interrupt_flag_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [INST_W-1:0] inst_mem [DEPTH];
   logic [INST_W-1:0] addr_mem [DEPTH];
   logic [INT_W-1:0]  flag_mem [DEPTH];

   logic [PW-1:0] rptr;
   logic [PW-1:0] wptr;
   logic [CW-1:0] count;
   logic          full;
   logic          empty;
   logic          pop_en;
   logic          push_fire;
   logic          pop_fire;
   logic          bypass;

   assign full   = (count == FULL_CNT);
   assign empty  = (count == '0);
   assign pop_en = pop_ready_i && (hold_flag_i < HOLD_LEVEL) && !flush_i;

`ifdef FETCH_QUEUE_BYPASS_EN
   assign bypass = empty && push_valid_i && pop_en;
`else
   assign bypass = 1'b0;
`endif

   // A bypassed entry is consumed directly and must not also be stored.
   assign push_fire = push_valid_i && !full && !flush_i && !bypass;
   assign pop_fire  = !empty && pop_en;

   assign push_ready_o = !full;
   assign count_o      = count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rptr  <= '0;
         wptr  <= '0;
         count <= '0;
      end else if (flush_i) begin
         rptr  <= '0;
         wptr  <= '0;
         count <= '0;
      end else begin
         if (push_fire) wptr <= wptr + 1'b1;
         if (pop_fire)  rptr <= rptr + 1'b1;
         case ({push_fire, pop_fire})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_fire) begin
         inst_mem[wptr] <= inst_i;
         addr_mem[wptr] <= inst_addr_i;
         flag_mem[wptr] <= interrupt_flag_i;
      end
   end

   always_comb begin
      pop_valid_o      = !empty;
      inst_o           = NOP_INST;
      inst_addr_o      = '0;
      interrupt_flag_o = '0;
      if (!empty) begin
         inst_o           = inst_mem[rptr];
         inst_addr_o      = addr_mem[rptr];
         interrupt_flag_o = flag_mem[rptr];
      end else if (bypass) begin
         pop_valid_o      = 1'b1;
         inst_o           = inst_i;
         inst_addr_o      = inst_addr_i;
         interrupt_flag_o = interrupt_flag_i;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed and random stimulus against a queue-based reference model of fetch_queue.
`default_nettype none

module tb_fetch_queue;

   localparam int DEPTH = 4;
   localparam logic [31:0] NOP = 32'h00000013;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] addr;
      logic [7:0]  flg;
   } entry_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        push_valid_i;
   logic        push_ready_o;
   logic [31:0] inst_i;
   logic [31:0] inst_addr_i;
   logic [7:0]  interrupt_flag_i;
   logic        pop_ready_i;
   logic [2:0]  hold_flag_i;
   logic        flush_i;
   logic        pop_valid_o;
   logic [31:0] inst_o;
   logic [31:0] inst_addr_o;
   logic [7:0]  interrupt_flag_o;
   logic [2:0]  count_o;

   entry_t q[$];
   int n_assert = 0;
   int n_fail   = 0;

   fetch_queue #(.DEPTH(DEPTH)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .push_valid_i     (push_valid_i),
      .push_ready_o     (push_ready_o),
      .inst_i           (inst_i),
      .inst_addr_i      (inst_addr_i),
      .interrupt_flag_i (interrupt_flag_i),
      .pop_ready_i      (pop_ready_i),
      .hold_flag_i      (hold_flag_i),
      .flush_i          (flush_i),
      .pop_valid_o      (pop_valid_o),
      .inst_o           (inst_o),
      .inst_addr_o      (inst_addr_o),
      .interrupt_flag_o (interrupt_flag_o),
      .count_o          (count_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      entry_t h;
      if (q.size() > 0) h = q[0];
      else h = '{inst: NOP, addr: 32'h0, flg: 8'h0};
      chk("pop_valid",  {31'b0, pop_valid_o},  {31'b0, q.size() > 0});
      chk("push_ready", {31'b0, push_ready_o}, {31'b0, q.size() < DEPTH});
      chk("count",      {29'b0, count_o},      32'(q.size()));
      chk("inst",       inst_o,                h.inst);
      chk("addr",       inst_addr_o,           h.addr);
      chk("flags",      {24'b0, interrupt_flag_o}, {24'b0, h.flg});
   endtask

   // Drive one cycle of inputs (called right after a negedge), advance the model at the
   // posedge, then check outputs at the following negedge.
   task automatic step(input logic pv, input logic [31:0] addr, input logic pr,
                       input logic [2:0] hold, input logic fl);
      logic push_ok, pop_ok;
      entry_t e;
      e = '{inst: $urandom, addr: addr, flg: 8'($urandom)};
      push_valid_i     = pv;
      inst_i           = e.inst;
      inst_addr_i      = e.addr;
      interrupt_flag_i = e.flg;
      pop_ready_i      = pr;
      hold_flag_i      = hold;
      flush_i          = fl;
      push_ok = pv && (q.size() < DEPTH) && !fl;
      pop_ok  = (q.size() > 0) && pr && (hold < 3'd2) && !fl;
      @(posedge clk);
      if (fl) q.delete();
      else begin
         if (pop_ok)  void'(q.pop_front());
         if (push_ok) q.push_back(e);
      end
      @(negedge clk);
      check_model();
   endtask

   initial begin
      rst_n = 1'b0;
      push_valid_i = 1'b0; inst_i = '0; inst_addr_i = '0; interrupt_flag_i = '0;
      pop_ready_i = 1'b0; hold_flag_i = '0; flush_i = 1'b0;

      // Reset then idle
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_inst", inst_o, 32'h13);
      chk("rst_addr", inst_addr_o, 32'h0);
      chk("rst_cnt", {29'b0, count_o}, 32'd0);
      check_model();
      step(0, 0, 0, 0, 0);

      // Fill and drain
      for (int k = 0; k < 4; k++) step(1, 32'(4 * k), 0, 0, 0);
      chk("fill_cnt", {29'b0, count_o}, 32'd4);
      chk("fill_rdy", {31'b0, push_ready_o}, 32'd0);
      step(1, 32'h10, 0, 0, 0);
      chk("fifth_rej", {29'b0, count_o}, 32'd4);
      // full queue with pop and push together: push still rejected
      step(1, 32'h14, 1, 0, 0);
      chk("full_pp_cnt", {29'b0, count_o}, 32'd3);
      for (int k = 0; k < 4; k++) step(0, 0, 1, 0, 0);
      chk("drain_nop", inst_o, 32'h13);

      // Wrap-around with sustained push/pop
      step(1, 32'h100, 0, 0, 0);
      for (int k = 1; k <= 10; k++) step(1, 32'h100 + 32'(4 * k), 1, 0, 0);
      chk("wrap_cnt", {29'b0, count_o}, 32'd1);
      step(0, 0, 1, 0, 0);

      // Hold
      step(1, 32'h300, 0, 0, 0);
      step(1, 32'h304, 0, 0, 0);
      for (int k = 0; k < 3; k++) step(0, 0, 1, 3'b010, 0);
      chk("hold_addr", inst_addr_o, 32'h300);
      chk("hold_cnt", {29'b0, count_o}, 32'd2);
      step(0, 0, 1, 3'b001, 0);
      chk("hold_resume", inst_addr_o, 32'h304);
      step(0, 0, 1, 3'b000, 0);

      // Flush with concurrent push
      for (int k = 0; k < 3; k++) step(1, 32'h400 + 32'(4 * k), 0, 0, 0);
      step(1, 32'h200, 1, 0, 1);
      chk("flush_cnt", {29'b0, count_o}, 32'd0);
      chk("flush_inst", inst_o, 32'h13);
      for (int k = 0; k < 2; k++) step(0, 0, 1, 0, 0);

      // Async reset mid-stream
      for (int k = 0; k < 3; k++) step(1, 32'h500 + 32'(4 * k), 0, 0, 0);
      chk("pre_rst_cnt", {29'b0, count_o}, 32'd3);
      push_valid_i = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      q.delete();
      chk("arst_cnt", {29'b0, count_o}, 32'd0);
      chk("arst_inst", inst_o, 32'h13);
      chk("arst_valid", {31'b0, pop_valid_o}, 32'd0);
      check_model();
      @(negedge clk);
      rst_n = 1'b1;
      step(0, 0, 0, 0, 0);

      // Randomized traffic
      for (int k = 0; k < 400; k++) begin
         step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
              3'($urandom_range(0, 7)), ($urandom_range(0, 19) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
